// File: rtl/alu_result_sel_if.sv
// Handshake and data bundle for alu_result_sel: selector inputs, the registered
// valid/ready output stream, and the invalid-select debug counter.
interface alu_result_sel_if #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        opsel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_clr;
  logic [CNT_W-1:0]        err_cnt;

  modport master (
    output in_data, opsel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_err, out_valid, err_cnt
  );

  modport slave (
    input  in_data, opsel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_err, out_valid, err_cnt
  );
endinterface

// File: rtl/alu_result_sel.sv
// Registered NUM_IN:1 result selector with a two-entry skid buffer on the output
// stream; invalid selects yield zero data, an error flag and a saturating count.
module alu_result_sel #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned CNT_W  = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_result_sel_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_err_q, main_err_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q;

  logic accept;
  logic pop;
  logic acc_err;

  // Any opsel with no matching input leaves the zero/error defaults in place.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.opsel == SEL_W'(k)) begin
        sel_data = bus.in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign bus.in_ready = rdy_q & ~skid_valid_q;
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = main_valid_q & bus.out_ready;
  assign acc_err      = accept & sel_err;

  always_comb begin
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;

    if (!main_valid_q || pop) begin
      // Main is free this edge: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_err_d   = skid_err_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = sel_data;
        main_err_d   = sel_err;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = sel_data;
      skid_err_d   = sel_err;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.err_clr) begin
      cnt_d = acc_err ? CNT_W'(1) : '0;
    end else if (acc_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
      rdy_q        <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
      rdy_q        <= 1'b1;
    end
  end

  assign bus.out_data  = main_data_q;
  assign bus.out_err   = main_err_q;
  assign bus.out_valid = main_valid_q;
  assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_alu_result_sel.sv
// Bench for alu_result_sel: an 8-input instance for streaming, back-pressure and
// mid-stream reset, and a 6-input instance for invalid selects and random traffic.
module tb_alu_result_sel;
  logic clk;
  logic rst_n;

  alu_result_sel_if #(.WIDTH(128), .NUM_IN(8), .CNT_W(8)) b8 ();
  alu_result_sel_if #(.WIDTH(128), .NUM_IN(6), .CNT_W(8)) b6 ();

  alu_result_sel #(.WIDTH(128), .NUM_IN(8), .CNT_W(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  alu_result_sel #(.WIDTH(128), .NUM_IN(6), .CNT_W(8)) u6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   opsel;
    logic [127:0] exp_data;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic [127:0] d;
    logic         e;
  } beat_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int k);
    logic [7:0] b;
    b = 8'(k * 17);  // 8'h00, 8'h11, ... 8'h77
    return {16{b}};
  endfunction

  vec_t  vecs[8];
  beat_t q[$];
  beat_t nb;
  int    model_cnt;
  logic  acc, pop, hold_prev;
  logic  [127:0] prev_data;
  logic  prev_err;

  initial begin
    for (int k = 0; k < 8; k++) begin
      vecs[k].opsel    = 3'(k);
      vecs[k].exp_data = pat(k);
      vecs[k].exp_err  = 1'b0;
    end

    b8.in_valid = 1'b0; b8.opsel = '0; b8.out_ready = 1'b0; b8.err_clr = 1'b0;
    b6.in_valid = 1'b0; b6.opsel = '0; b6.out_ready = 1'b0; b6.err_clr = 1'b0;
    for (int k = 0; k < 8; k++) b8.in_data[k*128 +: 128] = pat(k);
    for (int k = 0; k < 6; k++) b6.in_data[k*128 +: 128] = ~pat(k);

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(b8.out_valid), 128'(0));
    check("rst_out_data", b8.out_data, '0);
    check("rst_out_err", 128'(b8.out_err), 128'(0));
    check("rst_err_cnt", 128'(b6.err_cnt), 128'(0));
    check("rst_in_ready_low", 128'(b8.in_ready), 128'(0));
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", 128'(b8.in_ready), 128'(0));
    @(negedge clk);
    check("in_ready_after_edge", 128'(b8.in_ready), 128'(1));

    // Streaming, table-driven
    b8.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b8.opsel    = vecs[i].opsel;
      b8.in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("stream_valid[%0d]", i), 128'(b8.out_valid), 128'(1));
      check($sformatf("stream_data[%0d]", i), b8.out_data, vecs[i].exp_data);
      check($sformatf("stream_err[%0d]", i), 128'(b8.out_err), 128'(vecs[i].exp_err));
    end
    b8.in_valid = 1'b0;
    @(negedge clk);
    check("stream_drained", 128'(b8.out_valid), 128'(0));

    // Back-pressure
    b8.out_ready = 1'b0;
    b8.in_valid  = 1'b1;
    b8.opsel     = 3'd3;
    @(negedge clk);
    check("bp_first", b8.out_data, pat(3));
    check("bp_ready_1", 128'(b8.in_ready), 128'(1));
    b8.opsel = 3'd5;
    @(negedge clk);
    check("bp_ready_0", 128'(b8.in_ready), 128'(0));
    check("bp_hold", b8.out_data, pat(3));
    b8.opsel = 3'd6;
    @(negedge clk);
    check("bp_third_blocked", 128'(b8.in_ready), 128'(0));
    check("bp_hold2", b8.out_data, pat(3));
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    @(negedge clk);
    check("bp_second_out", b8.out_data, pat(5));
    check("bp_valid_second", 128'(b8.out_valid), 128'(1));
    check("bp_ready_back", 128'(b8.in_ready), 128'(1));
    @(negedge clk);
    check("bp_empty", 128'(b8.out_valid), 128'(0));

    // Invalid select on the 6-input instance
    b6.out_ready = 1'b1;
    b6.in_valid  = 1'b1;
    b6.opsel     = 3'd7;
    @(negedge clk);
    check("inv_data", b6.out_data, '0);
    check("inv_err", 128'(b6.out_err), 128'(1));
    check("inv_cnt1", 128'(b6.err_cnt), 128'(1));
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("inv_cnt_sat", 128'(b6.err_cnt), 128'(255));
    b6.err_clr = 1'b1;
    @(negedge clk);
    check("clr_with_inv", 128'(b6.err_cnt), 128'(1));
    b6.in_valid = 1'b0;
    @(negedge clk);
    check("clr_alone", 128'(b6.err_cnt), 128'(0));
    check("inv_drained", 128'(b6.out_valid), 128'(0));
    b6.err_clr = 1'b0;

    // Random handshake against a queue model
    model_cnt = 0;
    hold_prev = 1'b0;
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int w = 0; w < 24; w++) b6.in_data[w*32 +: 32] = $urandom;
      b6.opsel     = 3'($urandom_range(0, 7));
      b6.in_valid  = ($urandom_range(0, 9) < 6);
      b6.out_ready = ($urandom_range(0, 9) < 6);
      b6.err_clr   = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      check("rnd_out_valid", 128'(b6.out_valid), 128'(q.size() > 0));
      check("rnd_in_ready", 128'(b6.in_ready), 128'(q.size() < 2));
      check("rnd_err_cnt", 128'(b6.err_cnt), 128'(model_cnt));
      if (q.size() > 0) begin
        check("rnd_data", b6.out_data, q[0].d);
        check("rnd_err", 128'(b6.out_err), 128'(q[0].e));
      end
      if (hold_prev) begin
        check("rnd_hold_data", b6.out_data, prev_data);
        check("rnd_hold_err", 128'(b6.out_err), 128'(prev_err));
      end
      hold_prev = b6.out_valid && !b6.out_ready;
      prev_data = b6.out_data;
      prev_err  = b6.out_err;
      acc = b6.in_valid && (q.size() < 2);
      pop = (q.size() > 0) && b6.out_ready;
      nb.e = (b6.opsel >= 3'd6);
      nb.d = nb.e ? 128'(0) : b6.in_data[int'(b6.opsel)*128 +: 128];
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(nb);
      if (b6.err_clr) model_cnt = (acc && nb.e) ? 1 : 0;
      else if (acc && nb.e && model_cnt < 255) model_cnt++;
      #1;
    end
    b6.in_valid = 1'b0;
    b6.err_clr  = 1'b0;

    // Mid-stream reset with both entries full
    @(negedge clk);
    b8.out_ready = 1'b0;
    b8.in_valid  = 1'b1;
    b8.opsel     = 3'd1;
    @(negedge clk);
    b8.opsel = 3'd2;
    @(negedge clk);
    b8.in_valid = 1'b0;
    check("mr_full", 128'(b8.in_ready), 128'(0));
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid_async", 128'(b8.out_valid), 128'(0));
    check("mr_data_async", b8.out_data, '0);
    check("mr_ready_low", 128'(b8.in_ready), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    b8.out_ready = 1'b1;
    #1 check("mr_ready_pre_edge", 128'(b8.in_ready), 128'(0));
    @(negedge clk);
    check("mr_ready_post_edge", 128'(b8.in_ready), 128'(1));
    for (int i = 0; i < 3; i++) begin
      check("mr_no_stale", 128'(b8.out_valid), 128'(0));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_sel.md
Name: alu_result_sel

Overview:
- Parametrised, registered successor of the 8:1 result multiplexer. Selects one of NUM_IN WIDTH-bit operation results by opsel and presents it on a valid/ready output through a two-entry skid buffer, so back-pressure from downstream never drops or duplicates a result.
- Invalid selects (opsel >= NUM_IN) produce zero data with an error flag instead of a high-impedance output.
- A saturating counter records invalid-select events for debug.

Parameters:
- WIDTH, 128, bit width of each result input and of out_data.
- NUM_IN, 8, number of selectable result inputs; legal range 2..64.
- SEL_W, $clog2(NUM_IN), width of opsel; derived, never overridden.
- CNT_W, 8, width of err_cnt.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened results; input k occupies bits [k*WIDTH +: WIDTH].
- opsel  input  SEL_W  selects input index.
- in_valid  input  1  in_data/opsel valid this cycle.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected result.
- out_err  output  1  beat was produced from an invalid opsel.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  downstream accepts this cycle.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_W  saturating count of accepted invalid-select beats.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_err=0, err_cnt=0.
  - Skid entry emptied.
  - in_ready=0 while rst_n is low; in_ready=1 from the first clock edge after deassertion.
- Accept: a beat is taken when in_valid && in_ready at a rising edge.
- Select:
  - sel_data = input[opsel] when opsel < NUM_IN.
  - Otherwise sel_data = 0 and sel_err = 1.
  - When NUM_IN is a power of two, every opsel is legal.
- Storage: two entries, main (drives outputs) and skid. Each holds data, err and valid.
- Latency: 1 cycle. A beat accepted at edge N appears on out_data with out_valid=1 after edge N when main was empty or draining.
- in_ready = !skid_valid (registered state; no combinational path from out_ready to in_ready).
- Per-edge rules (pop = out_valid && out_ready):
  - Main empty, accept: beat goes to main.
  - Main full, pop, accept, skid empty: beat goes to main (full throughput, one beat per cycle).
  - Main full, no pop, accept: beat goes to skid; in_ready falls next cycle.
  - Main full, pop, skid full: skid moves to main, skid empties, in_ready rises next cycle. No accept is possible this cycle because in_ready=0.
  - Main full, pop, no accept, skid empty: main empties; out_valid falls.
- Stability: while out_valid && !out_ready, out_data and out_err hold constant.
- Ordering: strict FIFO order; no beat lost or duplicated.
- err_cnt:
  - Increments on each accepted beat with sel_err=1 and saturates at 2^CNT_W-1.
  - err_clr has priority. err_clr and an invalid accept in the same cycle give err_cnt=1; err_clr alone gives 0.
- Reset mid-stream: all held beats are discarded immediately; outputs go to reset values asynchronously.
- X-safety: in_data and opsel are ignored when in_valid=0; no state changes.

Test Plan:
- Reset then streaming:
  - Stimulus: NUM_IN=8, WIDTH=128, input k = {16{8'hk0+k}}; opsel 0..7 on consecutive cycles with in_valid=1, out_ready=1.
  - Required: out_data equals input 0..7 in order, one per cycle, first beat 1 cycle after the first accept; out_err=0 throughout.
- Back-pressure:
  - Stimulus: out_ready=0 while sending opsel=3 then opsel=5.
  - Required: out_data holds input 3; in_ready=0 after the second accept; the third beat is not accepted.
  - Then: out_ready=1 yields input 3, then input 5; in_ready returns to 1 one cycle after the skid drains.
- Invalid select:
  - Stimulus: NUM_IN=6, opsel=7.
  - Required: out_data=0, out_err=1, err_cnt=1.
  - Then: 300 further invalid beats saturate err_cnt at 255.
  - Then: err_clr together with an invalid beat gives err_cnt=1.
- Random handshake:
  - Stimulus: random in_valid and out_ready over 10k cycles.
  - Required: the scoreboard sees an identical ordered stream; out_data never changes while out_valid && !out_ready.
- Reset mid-operation:
  - Stimulus: both entries full, rst_n pulsed low between clock edges.
  - Required: out_valid=0 immediately; no stale beat appears after reset; in_ready=1 one edge after release.
